decoder_nto2n_seq: RTL and testbench
====================================

Name: decoder_nto2n_seq

Overview:
Parametrised, registered N-to-2^N line decoder. Successor to the fixed 2-to-4 combinational decoder.
- Decode mode: a selector is accepted over a valid/ready handshake and the registered one-hot output holds until the next accept.
- Scan mode: the block walks the one-hot output across all lines at a programmable rate (row/digit strobing).
- Sits between control logic and enable lines of downstream banks/displays.

Parameters:
N, 2, selector width in bits (>=1)
NUM_OUT, 4, number of output lines; 1 <= NUM_OUT <= 2**N
SCAN_DIV, 4, enabled cycles each line is held in scan mode (>=1)
ACTIVE_LOW, 0, 1 = output lines inverted (asserted line low)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  clock enable; 0 freezes all state
mode  input  1  0 = decode, 1 = scan
sel  input  N  selector value
sel_valid  input  1  sel is valid this cycle
sel_ready  output  1  block accepts sel this cycle
dout  output  NUM_OUT  decoded lines (polarity per ACTIVE_LOW)
dout_valid  output  1  dout holds a decoded/scan value
err  output  1  last accepted sel was >= NUM_OUT
scan_idx  output  N  index of the active line in scan mode

Behaviour:
Interface: one clock, clk. Reset rst_n is synchronous and active-low.

Reset:
- When rst_n=0 at a clk edge, the reset applies regardless of en.
- Internal one-hot register oh = 0; dout = all 0 (all 1 if ACTIVE_LOW).
- dout_valid = 0, err = 0, scan_idx = 0, divider = 0, state = IDLE.

Output mapping:
- dout = ACTIVE_LOW ? ~oh : oh, registered, with no combinational path from sel.

Handshake:
- sel_ready = en & ~mode, combinational.
- Accept = sel_valid & sel_ready.

States:
- IDLE, DECODE, SCAN.
- Transitions are evaluated only when en=1. With en=0, every register holds.

Decode behaviour (mode=0):
- On accept with sel < NUM_OUT: next edge oh = 1<<sel, err = 0, dout_valid = 1, state = DECODE. Latency is 1 cycle.
- On accept with sel >= NUM_OUT: next edge oh = 0, err = 1, dout_valid = 1, state = DECODE.
- With no accept, outputs hold. Back-to-back accepts update every cycle.

Entering SCAN (mode=1 while state != SCAN):
- Next edge: state = SCAN, scan_idx = 0, divider = 0, oh = 1 (bit 0), dout_valid = 1, err = 0.

In SCAN:
- divider increments each enabled cycle.
- When divider == SCAN_DIV-1: divider = 0, and scan_idx = (scan_idx == NUM_OUT-1) ? 0 : scan_idx+1, with oh following the same edge.
- Each line is asserted for exactly SCAN_DIV enabled cycles. SCAN_DIV=1 steps every cycle. NUM_OUT=1 keeps bit 0 asserted.

Leaving SCAN (mode=0 while state == SCAN):
- With an accept in the same cycle: decode as above; the accept wins.
- Without an accept: oh = 0, dout_valid = 0, err = 0, state = IDLE.
- scan_idx is held, and is meaningful only in SCAN.

Other rules:
- A mode change while en=0 takes effect on the first cycle with en=1.
- Reset mid-scan or mid-decode returns all registers to reset values on that edge.
- Exactly one line is asserted whenever dout_valid=1 and err=0. No line is asserted when err=1 or dout_valid=0.

Test Plan:
1. Reset/decode (N=2, NUM_OUT=4, ACTIVE_LOW=0): hold rst_n=0 for 2 cycles -> dout=0000, dout_valid=0. Then accept sel=2 -> next cycle dout=0100, dout_valid=1, err=0. Hold sel_valid=0 for 5 cycles -> dout stays 0100.
2. Out-of-range (NUM_OUT=3): accept sel=3 -> dout=000, err=1, dout_valid=1. Then accept sel=0 -> dout=001, err=0.
3. Scan (NUM_OUT=3, SCAN_DIV=2): assert mode=1 -> dout sequence 001,001,010,010,100,100,001 on consecutive cycles, scan_idx 0,0,1,1,2,2,0. sel_ready=0 throughout.
4. Enable freeze: in scan, drop en for 3 cycles mid-step -> dout, scan_idx and divider are held, and the step resumes with the remaining count. With en=0 in decode mode, sel_valid=1 -> sel_ready=0 and no change.
5. Mode exit: leave scan with no sel_valid -> dout=0, dout_valid=0. Repeat the exit with sel_valid=1, sel=1 in the exit cycle -> next cycle dout=0010, dout_valid=1.
6. Polarity/reset mid-op (ACTIVE_LOW=1): reset -> dout=1111. Accept sel=3 -> dout=0111. Assert rst_n=0 for one cycle during scan -> dout=1111, dout_valid=0, scan_idx=0 on the next edge.

Source files
------------

// File: rtl/decoder_nto2n_seq.sv
// ---------------------------------------------------------------------------
// decoder_nto2n_seq
//
// Registered N-to-2^N line decoder with two operating modes:
//   decode (mode=0): a selector taken over a valid/ready handshake drives a
//                    one-hot output that holds until the next accept.
//   scan   (mode=1): the one-hot output walks across all lines, holding each
//                    line for SCAN_DIV enabled cycles (row/digit strobing).
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset (wins over en)
//   en          clock enable; 0 freezes every register
//   mode        0 = decode, 1 = scan
//   sel         selector value (N bits)
//   sel_valid   sel is valid this cycle
//   sel_ready   block accepts sel this cycle (en & ~mode)
//   dout        decoded lines, inverted when ACTIVE_LOW=1
//   dout_valid  dout holds a decoded or scan value
//   err         last accepted sel was >= NUM_OUT
//   scan_idx    index of the active line while scanning
// ---------------------------------------------------------------------------
module decoder_nto2n_seq #(
   parameter int N          = 2,
   parameter int NUM_OUT    = 4,
   parameter int SCAN_DIV   = 4,
   parameter int ACTIVE_LOW = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               mode,
   input  logic [N-1:0]       sel,
   input  logic               sel_valid,
   output logic               sel_ready,
   output logic [NUM_OUT-1:0] dout,
   output logic               dout_valid,
   output logic               err,
   output logic [N-1:0]       scan_idx
);

   localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [N-1:0]      IDX_LAST = N'(NUM_OUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      SCAN   = 2'd2
   } state_t;

   // One-hot of idx over the NUM_OUT implemented lines; indices at or beyond
   // NUM_OUT produce all zeros.
   function automatic logic [NUM_OUT-1:0] f_onehot(input logic [N-1:0] idx);
      logic [NUM_OUT-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         v[i] = ({1'b0, idx} == (N+1)'(i));
      end
      return v;
   endfunction

   // Widened by one bit so NUM_OUT == 2**N is representable.
   function automatic logic f_in_range(input logic [N-1:0] s);
      return ({1'b0, s} < (N+1)'(NUM_OUT));
   endfunction

   state_t             r_state,   w_state_nxt;
   logic [NUM_OUT-1:0] r_oh,      w_oh_nxt;
   logic               r_vld,     w_vld_nxt;
   logic               r_err,     w_err_nxt;
   logic [N-1:0]       r_idx,     w_idx_nxt;
   logic [DIV_W-1:0]   r_div,     w_div_nxt;
   logic               w_accept;
   logic [N-1:0]       w_idx_step;

   assign sel_ready  = en & ~mode;
   assign w_accept   = sel_valid & sel_ready;
   assign w_idx_step = (r_idx == IDX_LAST) ? '0 : r_idx + N'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_oh_nxt    = r_oh;
      w_vld_nxt   = r_vld;
      w_err_nxt   = r_err;
      w_idx_nxt   = r_idx;
      w_div_nxt   = r_div;
      if (en) begin
         if (mode) begin
            if (r_state != SCAN) begin
               w_state_nxt = SCAN;
               w_idx_nxt   = '0;
               w_div_nxt   = '0;
               w_oh_nxt    = f_onehot('0);
               w_vld_nxt   = 1'b1;
               w_err_nxt   = 1'b0;
            end else if (r_div == DIV_LAST) begin
               w_div_nxt = '0;
               w_idx_nxt = w_idx_step;
               w_oh_nxt  = f_onehot(w_idx_step);
            end else begin
               w_div_nxt = r_div + DIV_W'(1);
            end
         end else if (w_accept) begin
            // An accept also wins over the scan-exit clear.
            w_state_nxt = DECODE;
            w_vld_nxt   = 1'b1;
            w_oh_nxt    = f_onehot(sel);
            w_err_nxt   = ~f_in_range(sel);
         end else if (r_state == SCAN) begin
            // scan_idx deliberately keeps its last scan value.
            w_state_nxt = IDLE;
            w_oh_nxt    = '0;
            w_vld_nxt   = 1'b0;
            w_err_nxt   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_oh    <= '0;
         r_vld   <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= '0;
         r_div   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_oh    <= w_oh_nxt;
         r_vld   <= w_vld_nxt;
         r_err   <= w_err_nxt;
         r_idx   <= w_idx_nxt;
         r_div   <= w_div_nxt;
      end
   end

   // Polarity is applied to the registered one-hot only, so sel never reaches
   // dout combinationally.
   assign dout       = (ACTIVE_LOW != 0) ? ~r_oh : r_oh;
   assign dout_valid = r_vld;
   assign err        = r_err;
   assign scan_idx   = r_idx;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
module tb_decoder_nto2n_seq;

   logic       clk = 1'b0;
   logic       rst_n, en, mode, sel_valid;
   logic [1:0] sel;

   // A: NUM_OUT=3 SCAN_DIV=2; B: NUM_OUT=4 SCAN_DIV=3; C: NUM_OUT=4 SCAN_DIV=1 active-low
   logic       rdy_a, rdy_b, rdy_c;
   logic [2:0] dout_a;
   logic [3:0] dout_b, dout_c;
   logic       vld_a, vld_b, vld_c;
   logic       err_a, err_b, err_c;
   logic [1:0] idx_a, idx_b, idx_c;

   always #5 clk = ~clk;

   decoder_nto2n_seq #(.N(2), .NUM_OUT(3), .SCAN_DIV(2), .ACTIVE_LOW(0)) u_a (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
      .sel_valid(sel_valid), .sel_ready(rdy_a), .dout(dout_a),
      .dout_valid(vld_a), .err(err_a), .scan_idx(idx_a));

   decoder_nto2n_seq #(.N(2), .NUM_OUT(4), .SCAN_DIV(3), .ACTIVE_LOW(0)) u_b (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
      .sel_valid(sel_valid), .sel_ready(rdy_b), .dout(dout_b),
      .dout_valid(vld_b), .err(err_b), .scan_idx(idx_b));

   decoder_nto2n_seq #(.N(2), .NUM_OUT(4), .SCAN_DIV(1), .ACTIVE_LOW(1)) u_c (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
      .sel_valid(sel_valid), .sel_ready(rdy_c), .dout(dout_c),
      .dout_valid(vld_c), .err(err_c), .scan_idx(idx_c));

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model, one slot per instance.
   int         P_NOUT[3] = '{3, 4, 4};
   int         P_DIV[3]  = '{2, 3, 1};
   int         P_AL[3]   = '{0, 0, 1};
   logic [3:0] m_oh[3];
   logic       m_vld[3], m_err[3];
   int         m_idx[3], m_div[3], m_st[3];   // st: 0 idle, 1 decode, 2 scan

   typedef struct {
      int         k;
      logic [3:0] dout;
      logic       vld;
      logic       err;
      logic [1:0] idx;
   } exp_t;
   exp_t sb[$];

   task automatic model_step(input int k);
      exp_t       e;
      logic [3:0] mask;
      mask = 4'((1 << P_NOUT[k]) - 1);
      if (!rst_n) begin
         m_oh[k] = 4'd0; m_vld[k] = 1'b0; m_err[k] = 1'b0;
         m_idx[k] = 0; m_div[k] = 0; m_st[k] = 0;
      end else if (en) begin
         if (mode) begin
            if (m_st[k] != 2) begin
               m_st[k] = 2; m_idx[k] = 0; m_div[k] = 0;
               m_oh[k] = 4'd1; m_vld[k] = 1'b1; m_err[k] = 1'b0;
            end else if (m_div[k] + 1 >= P_DIV[k]) begin
               m_div[k] = 0;
               m_idx[k] = (m_idx[k] + 1) % P_NOUT[k];
               m_oh[k]  = 4'(1 << m_idx[k]);
            end else begin
               m_div[k]++;
            end
         end else if (sel_valid) begin
            m_st[k] = 1; m_vld[k] = 1'b1;
            if (int'(sel) < P_NOUT[k]) begin
               m_oh[k] = 4'(1 << sel); m_err[k] = 1'b0;
            end else begin
               m_oh[k] = 4'd0; m_err[k] = 1'b1;
            end
         end else if (m_st[k] == 2) begin
            m_st[k] = 0; m_oh[k] = 4'd0; m_vld[k] = 1'b0; m_err[k] = 1'b0;
         end
      end
      e.k    = k;
      e.dout = (P_AL[k] != 0) ? (~m_oh[k] & mask) : m_oh[k];
      e.vld  = m_vld[k];
      e.err  = m_err[k];
      e.idx  = 2'(m_idx[k]);
      sb.push_back(e);
   endtask

   function automatic logic [3:0] a_dout(input int k);
      case (k)
         0:       return {1'b0, dout_a};
         1:       return dout_b;
         default: return dout_c;
      endcase
   endfunction
   function automatic logic a_vld(input int k);
      case (k) 0: return vld_a; 1: return vld_b; default: return vld_c; endcase
   endfunction
   function automatic logic a_err(input int k);
      case (k) 0: return err_a; 1: return err_b; default: return err_c; endcase
   endfunction
   function automatic logic [1:0] a_idx(input int k);
      case (k) 0: return idx_a; 1: return idx_b; default: return idx_c; endcase
   endfunction
   function automatic logic a_rdy(input int k);
      case (k) 0: return rdy_a; 1: return rdy_b; default: return rdy_c; endcase
   endfunction

   // One clock: check the combinational handshake, predict, clock, compare.
   task automatic cycle(input int n = 1);
      exp_t e;
      repeat (n) begin
         #1;
         for (int k = 0; k < 3; k++) begin
            check($sformatf("sel_ready%0d", k), a_rdy(k), en & ~mode);
            model_step(k);
         end
         @(posedge clk);
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("dout%0d", e.k),  a_dout(e.k), e.dout);
            check($sformatf("vld%0d", e.k),   a_vld(e.k),  e.vld);
            check($sformatf("err%0d", e.k),   a_err(e.k),  e.err);
            check($sformatf("idx%0d", e.k),   a_idx(e.k),  e.idx);
         end
      end
   endtask

   logic [2:0] seq_d[7] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
   logic [1:0] seq_i[7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};

   initial begin
      rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel_valid = 1'b0; sel = 2'd0;

      // Reset
      cycle(2);
      check("rst_dout_b", dout_b, 4'b0000);
      check("rst_vld_b",  vld_b,  1'b0);
      check("rst_dout_c", dout_c, 4'b1111);

      // Decode sel=2, then hold
      rst_n = 1'b1; sel_valid = 1'b1; sel = 2'd2;
      cycle(1);
      check("dec2_dout_b", dout_b, 4'b0100);
      check("dec2_vld_b",  vld_b,  1'b1);
      check("dec2_err_b",  err_b,  1'b0);
      check("dec2_dout_c", dout_c, 4'b1011);
      sel_valid = 1'b0;
      cycle(5);
      check("hold_dout_b", dout_b, 4'b0100);

      // Out of range on the 3-line instance, then back in range
      sel_valid = 1'b1; sel = 2'd3;
      cycle(1);
      check("oor_dout_a", dout_a, 3'b000);
      check("oor_err_a",  err_a,  1'b1);
      check("oor_vld_a",  vld_a,  1'b1);
      check("al_dout_c",  dout_c, 4'b0111);
      sel = 2'd0;
      cycle(1);
      check("sel0_dout_a", dout_a, 3'b001);
      check("sel0_err_a",  err_a,  1'b0);

      // Scan walk
      sel_valid = 1'b0; mode = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cycle(1);
         check($sformatf("scan_dout_a[%0d]", i), dout_a, seq_d[i]);
         check($sformatf("scan_idx_a[%0d]", i),  idx_a,  seq_i[i]);
      end

      // Freeze mid-step, then resume with the remaining count
      cycle(1);
      en = 1'b0;
      cycle(3);
      check("frz_dout_a", dout_a, 3'b001);
      en = 1'b1;
      cycle(1);
      check("resume_dout_a", dout_a, 3'b010);
      check("resume_idx_a",  idx_a,  2'd1);

      // Exit scan without accept, then with accept
      mode = 1'b0;
      cycle(1);
      check("exit_dout_b", dout_b, 4'b0000);
      check("exit_vld_b",  vld_b,  1'b0);
      mode = 1'b1;
      cycle(3);
      mode = 1'b0; sel_valid = 1'b1; sel = 2'd1;
      cycle(1);
      check("exitacc_dout_b", dout_b, 4'b0010);
      check("exitacc_vld_b",  vld_b,  1'b1);

      // Disabled decode: no accept; a mode change waits for en
      en = 1'b0; sel = 2'd3;
      #1;
      check("frz_rdy_b", rdy_b, 1'b0);
      cycle(2);
      check("frz_dec_dout_b", dout_b, 4'b0010);
      mode = 1'b1; sel_valid = 1'b0;
      cycle(1);
      check("frz_mode_dout_b", dout_b, 4'b0010);
      en = 1'b1;
      cycle(1);
      check("late_scan_dout_b", dout_b, 4'b0001);

      // Reset in the middle of a scan, even with en low
      cycle(2);
      check("c_idx_pre_rst", idx_c, 2'd2);
      rst_n = 1'b0; en = 1'b0;
      cycle(1);
      check("midrst_dout_c", dout_c, 4'b1111);
      check("midrst_vld_c",  vld_c,  1'b0);
      check("midrst_idx_c",  idx_c,  2'd0);
      rst_n = 1'b1; en = 1'b1;

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         rst_n     = ($urandom_range(0, 59) != 0);
         en        = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 9) == 0) mode = ~mode;
         sel_valid = $urandom_range(0, 1);
         sel       = 2'($urandom_range(0, 3));
         cycle(1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
